// File: rtl/ssd_capture_if.sv
// ssd_capture_if: bundles the display scan lines and the capture results.
//   a_to_g      : segment lines, active low (bit 6 = a, bit 0 = g)
//   an          : anode lines, active low (bit i selects digit i)
//   dp          : decimal point, active low
//   numStorage  : reassembled 8-digit BCD value (digit i at [4i+3:4i])
//   dp_out      : per-digit decimal point state, 1 = lit
//   frame_valid : one-cycle pulse when numStorage/dp_out update
//   seg_err     : one-cycle pulse when an illegal pattern is committed
// master = display side (drives scan lines), slave = the capture block.
interface ssd_capture_if;
  logic [6:0]  a_to_g;
  logic [7:0]  an;
  logic        dp;
  logic [31:0] numStorage;
  logic [7:0]  dp_out;
  logic        frame_valid;
  logic        seg_err;

  modport master (
    output a_to_g, an, dp,
    input  numStorage, dp_out, frame_valid, seg_err
  );

  modport slave (
    input  a_to_g, an, dp,
    output numStorage, dp_out, frame_valid, seg_err
  );
endinterface

// File: rtl/ssd_capture.sv
// ssd_capture: seven-segment scan receiver. Samples the multiplexed
// segment/anode lines, commits each digit after it has dwelt stably for
// STABLE_CYCLES samples, decodes the segment pattern back to BCD and
// publishes a full 8-digit frame once every digit has been captured.
// Ports:
//   clk : system clock (same clock as the display driver)
//   rst : synchronous active-high reset
//   bus : ssd_capture_if.slave (scan lines in, frame results out)
module ssd_capture #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  ssd_capture_if.slave  bus
);

  localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES);

  // Returns {illegal, nibble}. Blank segments decode to F without error.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0000100: r = 5'h09;
      7'b1111111: r = 5'h0F;
      default:    r = 5'h1E;
    endcase
    return r;
  endfunction

  // Position of the (single) low anode bit.
  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [6:0]  seg_p0;
  logic [7:0]  an_p0;
  logic        dp_p0;
  logic [15:0] cnt;
  logic        commit_p1;

  logic [31:0] digits;
  logic [7:0]  dps;
  logic [7:0]  mask;
  logic [31:0] num_q;
  logic [7:0]  dp_out_q;
  logic        frame_valid_q;
  logic        seg_err_q;

  logic        match;
  logic        an_blank;
  logic        an_single;
  logic        capture;
  logic [4:0]  dec;
  logic [2:0]  idx;
  logic [7:0]  cap_mask;

  assign match = (bus.a_to_g == seg_p0) && (bus.an == an_p0) && (bus.dp == dp_p0);

  // ---- stage p0: input sample and stability counter ----
  always_ff @(posedge clk) begin
    seg_p0 <= bus.a_to_g;
    an_p0  <= bus.an;
    dp_p0  <= bus.dp;
  end

  // commit_p1 fires once, on the sample that brings cnt to CNT_MAX; the
  // saturated counter cannot produce a second pulse for the same dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 16'd0;
      commit_p1 <= 1'b0;
    end else if (match) begin
      if (cnt != CNT_MAX) cnt <= cnt + 16'd1;
      commit_p1 <= (cnt == CNT_MAX - 16'd1);
    end else begin
      cnt       <= 16'd1;
      commit_p1 <= 1'b0;
    end
  end

  // ---- stage p1: decode committed sample, capture, assemble frame ----
  assign an_blank  = (an_p0 == 8'hFF);
  assign an_single = $onehot(~an_p0);
  assign capture   = commit_p1 && an_single;
  assign dec       = decode_seg(seg_p0);
  assign idx       = low_index(an_p0);
  assign cap_mask  = capture ? ~an_p0 : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      digits        <= 32'h0;
      dps           <= 8'h00;
      mask          <= 8'h00;
      num_q         <= 32'h0;
      dp_out_q      <= 8'h00;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
    end else begin
      seg_err_q <= commit_p1 && !an_blank && (!an_single || dec[4]);
      if (capture) begin
        digits[{idx, 2'b00} +: 4] <= dec[3:0];
        dps[idx]                  <= ~dp_p0;
      end
      frame_valid_q <= (mask == 8'hFF);
      // A capture landing on the publish cycle starts the next frame.
      if (mask == 8'hFF) begin
        num_q    <= digits;
        dp_out_q <= dps;
        mask     <= cap_mask;
      end else begin
        mask <= mask | cap_mask;
      end
    end
  end

  assign bus.numStorage  = num_q;
  assign bus.dp_out      = dp_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.seg_err     = seg_err_q;

endmodule

// File: tb/tb_ssd_capture.sv
// tb_ssd_capture: directed bench for ssd_capture with STABLE_CYCLES = 16.
module tb_ssd_capture;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   fv_cnt = 0;
  int   err_cnt = 0;

  logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

  ssd_capture_if bif ();

  ssd_capture #(.STABLE_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bif.frame_valid) fv_cnt <= fv_cnt + 1;
    if (bif.seg_err)     err_cnt <= err_cnt + 1;
  end

  task automatic show(input logic [7:0] a, input logic [6:0] s, input logic d, input int n);
    @(negedge clk);
    bif.an = a;
    bif.a_to_g = s;
    bif.dp = d;
    repeat (n) @(posedge clk);
  endtask

  task automatic digit(input int i, input int v, input logic d, input int n);
    show(~(8'h01 << i), seg_tab[v], d, n);
  endtask

  task automatic idle(input int n);
    show(8'hFF, 7'h7F, 1'b1, n);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bif.numStorage !== 32'h0) begin errors++; $display("FAIL reset_num got %h want %h", bif.numStorage, 32'h0); end
    checks++; if (bif.dp_out !== 8'h0) begin errors++; $display("FAIL reset_dp got %h want %h", bif.dp_out, 8'h0); end
    checks++; if (bif.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", bif.frame_valid); end
    checks++; if (bif.seg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bif.seg_err); end
  endtask

  task automatic test_full_frame;
    int fv0, er0, lat;
    fv0 = fv_cnt; er0 = err_cnt; lat = -1;
    for (int i = 0; i < 7; i++) digit(i, i + 1, 1'b1, 20);
    @(negedge clk);
    bif.an = 8'h7F; bif.a_to_g = seg_tab[8]; bif.dp = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      if (bif.frame_valid && lat < 0) lat = j;
    end
    idle(5);
    checks++; if (lat !== 17) begin errors++; $display("FAIL full_latency got %0d want 17", lat); end
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL full_fv_count got %0d want 1", fv_cnt - fv0); end
    checks++; if (bif.numStorage !== 32'h87654321) begin errors++; $display("FAIL full_num got %h want 87654321", bif.numStorage); end
    checks++; if (bif.dp_out !== 8'h00) begin errors++; $display("FAIL full_dp got %h want 00", bif.dp_out); end
    checks++; if (err_cnt - er0 !== 0) begin errors++; $display("FAIL full_err got %0d want 0", err_cnt - er0); end
  endtask

  task automatic test_glitch;
    int fv0;
    fv0 = fv_cnt;
    for (int i = 0; i < 8; i++) if (i != 3) digit(i, 0, 1'b1, 20);
    digit(3, 3, 1'b1, 10);
    idle(3);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL glitch_short_commit got %0d want 0", fv_cnt - fv0); end
    digit(3, 8, 1'b1, 20);
    idle(5);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL glitch_fv got %0d want 1", fv_cnt - fv0); end
    checks++; if (bif.numStorage !== 32'h00008000) begin errors++; $display("FAIL glitch_num got %h want 00008000", bif.numStorage); end
  endtask

  task automatic test_illegal;
    int fv0, er0, lat;
    fv0 = fv_cnt; er0 = err_cnt; lat = -1;
    for (int i = 2; i < 5; i++) digit(i, i, 1'b1, 20);
    @(negedge clk);
    bif.an = 8'hDF; bif.a_to_g = 7'b1110000; bif.dp = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (bif.seg_err && lat < 0) lat = j;
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL illegal_err_latency got %0d want 16", lat); end
    for (int i = 6; i < 8; i++) digit(i, i, 1'b1, 20);
    show(8'hFC, seg_tab[0], 1'b1, 20);
    idle(3);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL illegal_multi_an_mask got %0d want 0", fv_cnt - fv0); end
    checks++; if (err_cnt - er0 !== 2) begin errors++; $display("FAIL illegal_err_count got %0d want 2", err_cnt - er0); end
    digit(0, 0, 1'b1, 20);
    digit(1, 1, 1'b1, 20);
    idle(5);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL illegal_fv got %0d want 1", fv_cnt - fv0); end
    checks++; if (bif.numStorage !== 32'h76E43210) begin errors++; $display("FAIL illegal_num got %h want 76E43210", bif.numStorage); end
  endtask

  task automatic test_overwrite_dp;
    int er0;
    er0 = err_cnt;
    digit(2, 4, 1'b1, 20);
    digit(2, 9, 1'b0, 20);
    for (int i = 0; i < 7; i++) if (i != 2) digit(i, 0, 1'b1, 20);
    show(8'h7F, 7'h7F, 1'b1, 20);
    idle(5);
    checks++; if (bif.numStorage !== 32'hF0000900) begin errors++; $display("FAIL overwrite_num got %h want F0000900", bif.numStorage); end
    checks++; if (bif.dp_out !== 8'h04) begin errors++; $display("FAIL overwrite_dp got %h want 04", bif.dp_out); end
    checks++; if (err_cnt - er0 !== 0) begin errors++; $display("FAIL overwrite_blank_err got %0d want 0", err_cnt - er0); end
  endtask

  task automatic test_reset_mid;
    int fv0;
    for (int i = 0; i < 5; i++) digit(i, 5, 1'b1, 20);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bif.numStorage !== 32'h0) begin errors++; $display("FAIL rstmid_num got %h want 0", bif.numStorage); end
    checks++; if (bif.dp_out !== 8'h0) begin errors++; $display("FAIL rstmid_dp got %h want 0", bif.dp_out); end
    fv0 = fv_cnt;
    for (int i = 0; i < 7; i++) digit(i, 0, 1'b1, 20);
    idle(5);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL rstmid_early_fv got %0d want 0", fv_cnt - fv0); end
    digit(7, 0, 1'b1, 20);
    idle(5);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL rstmid_fv got %0d want 1", fv_cnt - fv0); end
    checks++; if (bif.numStorage !== 32'h0) begin errors++; $display("FAIL rstmid_final_num got %h want 0", bif.numStorage); end
  endtask

  task automatic test_blanking;
    int fv0, er0;
    fv0 = fv_cnt; er0 = err_cnt;
    for (int i = 0; i < 8; i++) begin
      show(8'hFF, 7'h7F, 1'b1, 20);
      digit(i, i + 1, 1'b1, 20);
    end
    idle(5);
    checks++; if (bif.numStorage !== 32'h87654321) begin errors++; $display("FAIL blank_num got %h want 87654321", bif.numStorage); end
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL blank_fv got %0d want 1", fv_cnt - fv0); end
    checks++; if (err_cnt - er0 !== 0) begin errors++; $display("FAIL blank_err got %0d want 0", err_cnt - er0); end
    checks++; if (bif.dp_out !== 8'h00) begin errors++; $display("FAIL blank_dp got %h want 00", bif.dp_out); end
  endtask

  initial begin
    bif.an = 8'hFF;
    bif.a_to_g = 7'h7F;
    bif.dp = 1'b1;
    test_reset();
    test_full_frame();
    test_glitch();
    test_illegal();
    test_overwrite_dp();
    test_reset_mid();
    test_blanking();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssd_capture.md
# ssd_capture

Seven-segment scan receiver: the receiving end of the multiplexed display interface driven by `sdd_gen`. It watches the active-low segment and anode lines, waits for each digit to dwell stably, decodes the segment pattern back to a BCD nibble and reassembles the full 8-digit value. It sits in the verification and loopback path beside `top` and lets the display output be checked against the `bcd_32` count in hardware or in simulation.

## Interface
- `STABLE_CYCLES`, default 16: number of consecutive identical samples required before a digit is committed. Legal range is 2..65535.
- `clk  in  1`: system clock; the same clock that drives `sdd_gen`.
- `rst  in  1`: synchronous, active-high reset.
- `a_to_g  in  7`: segment lines, active low. Bit 6 is segment a and bit 0 is segment g.
- `an  in  8`: anode lines, active low. Bit i selects digit i; digit 0 is the least significant.
- `dp  in  1`: decimal point, active low.
- `numStorage  out  32`: reassembled value. Digit i occupies bits [4i+3:4i].
- `dp_out  out  8`: decimal-point state per digit, 1 = lit. Updated together with `numStorage`.
- `frame_valid  out  1`: one-cycle pulse when `numStorage` and `dp_out` are updated.
- `seg_err  out  1`: one-cycle pulse when an illegal pattern is committed.

## Operation
**Input sampling and stability**
- All inputs are registered once; the registered sample is S. The stability counter `cnt` is 16 bits.
- If the current inputs equal S: `cnt` increments and saturates at `STABLE_CYCLES`. Otherwise `cnt` clears to 1.
- A commit happens exactly once per dwell, on the edge where `cnt` reaches `STABLE_CYCLES`.

**Anode classification at commit**
- `an` = 8'hFF (blanking): ignored. No capture, no error.
- Exactly one bit low: capture into digit index i, the position of that low bit.
- Two or more bits low: `seg_err` pulses. Nothing is captured.

**Segment decode (a_to_g → nibble)**
- 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
- 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
- 1111111 (blank) → 4'hF, no error.
- Any other pattern → 4'hE, and `seg_err` pulses. The digit is still captured.

**Frame assembly**
- On capture: the working digit register i ← nibble, working dp bit i ← ~dp, and mask[i] ← 1.
- Recapturing a digit before the frame completes overwrites it; the latest value wins.
- When the mask becomes 8'hFF, on the next edge:
  - `numStorage` ← working digits,
  - `dp_out` ← working dp bits,
  - `frame_valid` = 1 for that cycle,
  - the mask clears.
- A capture in the same cycle that the mask clears is kept: the new mask is the one-hot for that digit only.

**Reset**
- Reset clears `numStorage`, `dp_out`, the working registers, the mask and `cnt` to 0, and forces `frame_valid` and `seg_err` to 0.
- Reset mid-frame discards any partial frame. Published outputs hold until the next complete frame.

## Timing
- Inputs applied before edge k and held stable: commit occurs at edge k+`STABLE_CYCLES`.
- `seg_err` is high in the cycle after the commit edge.
- If that commit completes the frame, `numStorage` and `dp_out` update at edge k+`STABLE_CYCLES`+1, with `frame_valid` high in the following cycle.
- A dwell shorter than `STABLE_CYCLES` cycles is never committed; glitches are ignored.
- A dwell longer than `STABLE_CYCLES` yields a single commit; the saturated counter does not re-trigger.
- Outputs are stable between `frame_valid` pulses.

## Test plan
- **Full frame:** after reset, scan digits 0..7 showing 1,2,3,4,5,6,7,8, each held 20 cycles with `STABLE_CYCLES`=16. Expect `numStorage` = 32'h87654321, one `frame_valid` pulse, `dp_out` = 0.
- **Glitch rejection:** hold digit 3 at pattern 0000110 for 10 cycles, then 0000000 for 20 cycles. Expect only digit 3 = 8 to be captured, with no commit for the short dwell.
- **Illegal patterns:**
  - Commit `an` = 8'hFC (two digits low): expect a `seg_err` pulse and no mask change.
  - Commit pattern 1110000 on digit 5: expect a `seg_err` pulse, then nibble E at [23:20] after the frame completes.
- **Overwrite and dp:** capture digit 2 = 4, recapture digit 2 = 9 with `dp` = 0, then complete the frame. Expect bits [11:8] = 9 and `dp_out` = 8'h04.
- **Reset mid-frame:** capture digits 0..4, assert `rst` for 1 cycle, then scan a full frame of all 0s. Expect no `frame_valid` until all 8 digits are captured after reset, then `numStorage` = 0.
- **Blanking:** insert `an` = 8'hFF dwells between digits. Expect the same result as the full-frame case, with no `seg_err`.
